// File: rtl/mipi_lane_lp_hs_seq.sv
// MIPI D-PHY style lane sequencer: walks LP11 -> LP01 -> LP00 -> HS-zero -> HS payload
// -> HS-trail -> LP11 exit, with a per-lane enable mask captured at the start of each entry.
module mipi_lane_lp_hs_seq #(
   parameter int LANES   = 1,
   parameter int T_LPX   = 4,
   parameter int T_PREP  = 3,
   parameter int T_ZERO  = 6,
   parameter int T_TRAIL = 5,
   parameter int T_EXIT  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hs_req,
   input  logic [LANES-1:0] lane_en,
   output logic [LANES-1:0] lp_p,
   output logic [LANES-1:0] lp_n,
   output logic [LANES-1:0] hs_oe,
   output logic             hs_zero,
   output logic             hs_trail,
   output logic             hs_ready,
   output logic             entry_done,
   output logic             exit_done,
   output logic             busy,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      IDLE, LP01, LP00, HS_ZERO, HS_ACTIVE, HS_TRAIL, LP_EXIT
   } state_t;

   // Counter holds "cycles remaining minus one"; a state ends on the edge where it reads 0.
   localparam logic [7:0] LD_LPX   = 8'(T_LPX - 1);
   localparam logic [7:0] LD_PREP  = 8'(T_PREP - 1);
   localparam logic [7:0] LD_ZERO  = 8'(T_ZERO - 1);
   localparam logic [7:0] LD_TRAIL = 8'(T_TRAIL - 1);
   localparam logic [7:0] LD_EXIT  = 8'(T_EXIT - 1);

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [LANES-1:0] mask_q, mask_d;
   logic [LANES-1:0] lp_p_q, lp_p_d, lp_n_q, lp_n_d, hs_oe_q, hs_oe_d;
   logic             hs_zero_q, hs_zero_d, hs_trail_q, hs_trail_d, hs_ready_q, hs_ready_d;
   logic             entry_done_q, entry_done_d, exit_done_q, exit_done_d, busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
      case (state_q)
         IDLE: if (hs_req) begin
            state_d = LP01;
            cnt_d   = LD_LPX;
            mask_d  = lane_en;
         end
         LP01: if (cnt_q == 8'd0) begin
            state_d = LP00;
            cnt_d   = LD_PREP;
         end
         LP00: if (cnt_q == 8'd0) begin
            state_d = HS_ZERO;
            cnt_d   = LD_ZERO;
         end
         HS_ZERO: if (cnt_q == 8'd0) begin
            if (hs_req) begin
               state_d = HS_ACTIVE;
               cnt_d   = 8'd0;
            end else begin
               state_d = HS_TRAIL;
               cnt_d   = LD_TRAIL;
            end
         end
         HS_ACTIVE: if (!hs_req) begin
            state_d = HS_TRAIL;
            cnt_d   = LD_TRAIL;
         end
         HS_TRAIL: if (cnt_q == 8'd0) begin
            state_d = LP_EXIT;
            cnt_d   = LD_EXIT;
         end
         LP_EXIT: if (cnt_q == 8'd0) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      // Outputs are decoded from the next state so they line up with state_q after the edge.
      lp_p_d  = '1;
      lp_n_d  = '1;
      hs_oe_d = '0;
      case (state_d)
         LP01: lp_p_d = ~mask_d;
         LP00: begin
            lp_p_d = ~mask_d;
            lp_n_d = ~mask_d;
         end
         HS_ZERO, HS_ACTIVE, HS_TRAIL: begin
            lp_p_d  = ~mask_d;
            lp_n_d  = ~mask_d;
            hs_oe_d = mask_d;
         end
         default: ;
      endcase
      hs_zero_d    = (state_d == HS_ZERO);
      hs_trail_d   = (state_d == HS_TRAIL);
      hs_ready_d   = (state_d == HS_ACTIVE);
      entry_done_d = (state_d == HS_ACTIVE) && (state_q != HS_ACTIVE);
      exit_done_d  = (state_d == IDLE) && (state_q == LP_EXIT);
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         mask_q       <= '1;
         lp_p_q       <= '1;
         lp_n_q       <= '1;
         hs_oe_q      <= '0;
         hs_zero_q    <= 1'b0;
         hs_trail_q   <= 1'b0;
         hs_ready_q   <= 1'b0;
         entry_done_q <= 1'b0;
         exit_done_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mask_q       <= mask_d;
         lp_p_q       <= lp_p_d;
         lp_n_q       <= lp_n_d;
         hs_oe_q      <= hs_oe_d;
         hs_zero_q    <= hs_zero_d;
         hs_trail_q   <= hs_trail_d;
         hs_ready_q   <= hs_ready_d;
         entry_done_q <= entry_done_d;
         exit_done_q  <= exit_done_d;
         busy_q       <= busy_d;
      end
   end

   assign lp_p       = lp_p_q;
   assign lp_n       = lp_n_q;
   assign hs_oe      = hs_oe_q;
   assign hs_zero    = hs_zero_q;
   assign hs_trail   = hs_trail_q;
   assign hs_ready   = hs_ready_q;
   assign entry_done = entry_done_q;
   assign exit_done  = exit_done_q;
   assign busy       = busy_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mipi_lane_lp_hs_seq.sv
// Directed vector bench for the two-lane LP/HS sequencer with default timing parameters.
module tb_mipi_lane_lp_hs_seq;

   logic       clk;
   logic       rst;
   logic       hs_req;
   logic [1:0] lane_en;
   logic [1:0] lp_p, lp_n, hs_oe;
   logic       hs_zero, hs_trail, hs_ready, entry_done, exit_done, busy;
   logic [2:0] dbg_state;

   mipi_lane_lp_hs_seq #(.LANES(2)) dut (
      .clk(clk), .rst(rst), .hs_req(hs_req), .lane_en(lane_en),
      .lp_p(lp_p), .lp_n(lp_n), .hs_oe(hs_oe),
      .hs_zero(hs_zero), .hs_trail(hs_trail), .hs_ready(hs_ready),
      .entry_done(entry_done), .exit_done(exit_done), .busy(busy),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output word: {lp_p, lp_n, hs_oe, hs_zero, hs_trail, hs_ready, entry_done, exit_done, busy}
   localparam logic [11:0] O_RST     = {2'b11, 2'b11, 2'b00, 6'b000000};
   localparam logic [11:0] O_EXITD   = {2'b11, 2'b11, 2'b00, 6'b000010};
   localparam logic [11:0] O_LP01    = {2'b00, 2'b11, 2'b00, 6'b000001};
   localparam logic [11:0] O_LP00    = {2'b00, 2'b00, 2'b00, 6'b000001};
   localparam logic [11:0] O_ZERO    = {2'b00, 2'b00, 2'b11, 6'b100001};
   localparam logic [11:0] O_ACTE    = {2'b00, 2'b00, 2'b11, 6'b001101};
   localparam logic [11:0] O_ACT     = {2'b00, 2'b00, 2'b11, 6'b001001};
   localparam logic [11:0] O_TRAIL   = {2'b00, 2'b00, 2'b11, 6'b010001};
   localparam logic [11:0] O_EXIT    = {2'b11, 2'b11, 2'b00, 6'b000001};
   localparam logic [11:0] O_LP01_M  = {2'b01, 2'b11, 2'b00, 6'b000001};
   localparam logic [11:0] O_LP00_M  = {2'b01, 2'b01, 2'b00, 6'b000001};
   localparam logic [11:0] O_ZERO_M  = {2'b01, 2'b01, 2'b10, 6'b100001};
   localparam logic [11:0] O_ACTE_M  = {2'b01, 2'b01, 2'b10, 6'b001101};
   localparam logic [11:0] O_TRAIL_M = {2'b01, 2'b01, 2'b10, 6'b010001};

   typedef struct packed {
      logic        rst;
      logic        req;
      logic [1:0]  en;
      logic [11:0] exp;
   } vec_t;

   vec_t        tbl[$];
   logic [11:0] exp_q[$];
   int          n_cmp;
   int          n_fail;

   task automatic add(input int n, input logic r, input logic q, input logic [1:0] e,
                      input logic [11:0] x);
      vec_t v;
      v.rst = r;
      v.req = q;
      v.en  = e;
      v.exp = x;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   task automatic check_word(input string name, input int idx);
      logic [11:0] act;
      logic [11:0] exp;
      act = {lp_p, lp_n, hs_oe, hs_zero, hs_trail, hs_ready, entry_done, exit_done, busy};
      exp = exp_q.pop_front();
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int n;
      n_cmp   = 0;
      n_fail  = 0;
      rst     = 1'b1;
      hs_req  = 1'b0;
      lane_en = 2'b11;

      // Reset and idle
      add(2, 1, 0, 2'b11, O_RST);
      add(1, 0, 0, 2'b11, O_RST);
      // Full entry, payload, exit
      add(4, 0, 1, 2'b11, O_LP01);
      add(3, 0, 1, 2'b11, O_LP00);
      add(6, 0, 1, 2'b11, O_ZERO);
      add(1, 0, 1, 2'b11, O_ACTE);
      add(3, 0, 1, 2'b11, O_ACT);
      add(5, 0, 0, 2'b11, O_TRAIL);
      add(8, 0, 0, 2'b11, O_EXIT);
      add(1, 0, 0, 2'b11, O_EXITD);
      add(2, 0, 0, 2'b11, O_RST);
      // One-cycle request: entry runs to HS-zero end, then straight to trail
      add(1, 0, 1, 2'b11, O_LP01);
      add(3, 0, 0, 2'b11, O_LP01);
      add(3, 0, 0, 2'b11, O_LP00);
      add(6, 0, 0, 2'b11, O_ZERO);
      add(5, 0, 0, 2'b11, O_TRAIL);
      add(8, 0, 0, 2'b11, O_EXIT);
      add(1, 0, 0, 2'b11, O_EXITD);
      add(1, 0, 0, 2'b11, O_RST);
      // Lane 0 masked at entry; lane_en change mid-sequence must not take effect
      add(1, 0, 1, 2'b10, O_LP01_M);
      add(3, 0, 1, 2'b11, O_LP01_M);
      add(3, 0, 1, 2'b11, O_LP00_M);
      add(6, 0, 1, 2'b11, O_ZERO_M);
      add(1, 0, 1, 2'b11, O_ACTE_M);
      add(5, 0, 0, 2'b11, O_TRAIL_M);
      add(8, 0, 0, 2'b11, O_EXIT);
      add(1, 0, 0, 2'b11, O_EXITD);
      // Next entry picks up both lanes; reset in HS_ACTIVE aborts, then clean restart
      add(4, 0, 1, 2'b11, O_LP01);
      add(3, 0, 1, 2'b11, O_LP00);
      add(6, 0, 1, 2'b11, O_ZERO);
      add(1, 0, 1, 2'b11, O_ACTE);
      add(1, 0, 1, 2'b11, O_ACT);
      add(1, 1, 1, 2'b11, O_RST);
      add(4, 0, 1, 2'b11, O_LP01);
      add(3, 0, 1, 2'b11, O_LP00);
      add(6, 0, 1, 2'b11, O_ZERO);
      add(1, 0, 1, 2'b11, O_ACTE);
      // Request re-raised during LP_EXIT: exit finishes, one IDLE cycle, then LP01
      add(5, 0, 0, 2'b11, O_TRAIL);
      add(6, 0, 0, 2'b11, O_EXIT);
      add(2, 0, 1, 2'b11, O_EXIT);
      add(1, 0, 1, 2'b11, O_EXITD);
      add(1, 0, 1, 2'b11, O_LP01);
      add(2, 1, 0, 2'b11, O_RST);

      for (int i = 0; i < tbl.size(); i++) begin
         rst     = tbl[i].rst;
         hs_req  = tbl[i].req;
         lane_en = tbl[i].en;
         exp_q.push_back(tbl[i].exp);
         @(posedge clk);
         #1;
         check_word("vec", i);
      end

      // Entry latency: edge sampling hs_req=1 counts as cycle 1
      rst    = 1'b0;
      hs_req = 1'b1;
      @(posedge clk);
      #1;
      n = 1;
      while (!hs_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_int("entry_latency", n, 14);
      check_int("entry_done_with_ready", int'(entry_done), 1);

      // Exit latency to exit_done
      hs_req = 1'b0;
      @(posedge clk);
      #1;
      n = 1;
      while (!exit_done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_int("exit_latency", n, 14);
      check_int("busy_at_exit_done", int'(busy), 0);
      check_int("state_idle_at_exit_done", int'(dbg_state), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
